// File: rtl/object_ram_arbiter.sv
// Shares the sprite object SRAM between the CPU window (r/w) and the scan engine (read-only).
// Latency: request seen in IDLE at cycle N -> ADDR N+1, STROBE N+2, one-cycle ack in DONE at N+3.
// Backpressure: level requests are held until ack; scan has priority, a starvation count forces a CPU slot.
module object_ram_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK_6M,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_rnw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_wait_n,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] scan_rdata,
  output logic              scan_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wdata_oe,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_STROBE, S_DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_SCAN} owner_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t     state_q, state_d;
  owner_t     owner_q;
  logic       rnw_q, rnw_d;
  logic [3:0] starve_cnt;
  logic       grant_cpu, grant_scan;
  logic       ce_n_d, oe_n_d, we_n_d, wdata_oe_d;

  // Arbitration, next state and the next value of every SRAM strobe.
  // A requester still holding its request in DONE is re-arbitrated at once,
  // so a lone requester streams one access every three cycles.
  always_comb begin
    grant_cpu  = 1'b0;
    grant_scan = 1'b0;
    state_d    = state_q;
    rnw_d      = rnw_q;
    ce_n_d     = 1'b1;
    oe_n_d     = 1'b1;
    we_n_d     = 1'b1;
    wdata_oe_d = 1'b0;

    if (state_q == S_IDLE || state_q == S_DONE) begin
      if (cpu_req && (!scan_req || starve_cnt == STARVE_MAX)) grant_cpu = 1'b1;
      else if (scan_req)                                      grant_scan = 1'b1;
    end

    if (grant_cpu)       rnw_d = cpu_rnw;
    else if (grant_scan) rnw_d = 1'b1;

    case (state_q)
      S_IDLE:   if (grant_cpu || grant_scan) state_d = S_ADDR;
      S_ADDR:   state_d = S_STROBE;
      S_STROBE: state_d = S_DONE;
      S_DONE:   state_d = (grant_cpu || grant_scan) ? S_ADDR : S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (state_d != S_IDLE) begin
      ce_n_d     = 1'b0;
      wdata_oe_d = ~rnw_d;
    end
    if (state_d == S_STROBE) begin
      oe_n_d = ~rnw_d;
      we_n_d = rnw_d;
    end
  end

  // State, grant registers and glitch-free registered strobes/acks.
  always_ff @(posedge CLK_6M or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_NONE;
      rnw_q        <= 1'b1;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      ram_ce_n     <= 1'b1;
      ram_oe_n     <= 1'b1;
      ram_we_n     <= 1'b1;
      ram_wdata_oe <= 1'b0;
      cpu_ack      <= 1'b0;
      scan_ack     <= 1'b0;
    end else begin
      state_q      <= state_d;
      rnw_q        <= rnw_d;
      ram_ce_n     <= ce_n_d;
      ram_oe_n     <= oe_n_d;
      ram_we_n     <= we_n_d;
      ram_wdata_oe <= wdata_oe_d;
      cpu_ack      <= (state_d == S_DONE) && (owner_q == OWN_CPU);
      scan_ack     <= (state_d == S_DONE) && (owner_q == OWN_SCAN);
      if (grant_cpu) begin
        owner_q   <= OWN_CPU;
        ram_addr  <= cpu_addr;
        ram_wdata <= cpu_wdata;
      end else if (grant_scan) begin
        owner_q  <= OWN_SCAN;
        ram_addr <= scan_addr;
      end else if (state_d == S_IDLE) begin
        owner_q <= OWN_NONE;
      end
    end
  end

  // Read data is captured on the edge leaving STROBE into the owner's register.
  always_ff @(posedge CLK_6M or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata  <= '0;
      scan_rdata <= '0;
    end else if (state_q == S_STROBE && rnw_q) begin
      if (owner_q == OWN_CPU) cpu_rdata  <= ram_rdata;
      else                    scan_rdata <= ram_rdata;
    end
  end

  // Counts scan grants taken while the CPU waits; cleared by a CPU grant or an idle CPU.
  always_ff @(posedge CLK_6M or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!cpu_req || grant_cpu) begin
      starve_cnt <= '0;
    end else if (grant_scan && starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign cpu_wait_n = ~(cpu_req & ~cpu_ack);

endmodule

// File: tb/tb_object_ram_arbiter.sv
// Self-checking bench for object_ram_arbiter: cycle table, corner sequences, random traffic.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: bench requesters hold req until ack, then drop or re-request.
module tb_object_ram_arbiter;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;
  localparam int STARVE_LIMIT = 4;

  logic              CLK_6M = 1'b0;
  logic              rst_n = 1'b1;
  logic              cpu_req = 1'b0;
  logic              cpu_rnw = 1'b1;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_wait_n;
  logic              scan_req = 1'b0;
  logic [ADDR_W-1:0] scan_addr = '0;
  logic [DATA_W-1:0] scan_rdata;
  logic              scan_ack;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_ce_n, ram_oe_n, ram_we_n, ram_wdata_oe;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  object_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .CLK_6M(CLK_6M), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait_n(cpu_wait_n),
    .scan_req(scan_req), .scan_addr(scan_addr), .scan_rdata(scan_rdata), .scan_ack(scan_ack),
    .ram_addr(ram_addr), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
    .ram_wdata(ram_wdata), .ram_wdata_oe(ram_wdata_oe), .ram_rdata(ram_rdata)
  );

  always #5 CLK_6M = ~CLK_6M;

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [7:0] init_val(input logic [12:0] a);
    return a[7:0] ^ {3'b000, a[12:8]} ^ 8'h5A;
  endfunction

  // SRAM model: asynchronous read, write on the rising edge that ends a low we_n cycle.
  logic [DATA_W-1:0] sram [0:(1<<ADDR_W)-1];
  assign ram_rdata = sram[ram_addr];
  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) sram[i] = init_val(13'(i));
    sram[13'h040] = 8'h3C;
    forever begin
      @(posedge CLK_6M);
      if (!ram_ce_n && !ram_we_n) sram[ram_addr] <= ram_wdata;
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_6M);
    #1;
  endtask

  typedef struct {
    logic        cpu_req, cpu_rnw, scan_req;
    logic        ce_n, oe_n, we_n, woe, cack, sack, wait_n;
    logic [12:0] addr;
    logic [7:0]  rd;
  } vec_t;

  function automatic vec_t mk(input logic cr, rw, sr, ce, oe, we, woe, ca, sa, wn,
                              input logic [12:0] ad, input logic [7:0] rd);
    vec_t v;
    v.cpu_req = cr; v.cpu_rnw = rw; v.scan_req = sr;
    v.ce_n = ce; v.oe_n = oe; v.we_n = we; v.woe = woe;
    v.cack = ca; v.sack = sa; v.wait_n = wn; v.addr = ad; v.rd = rd;
    return v;
  endfunction

  vec_t tbl [16];

  // Reference model state (transaction level: busy flag, cycles to ack, owner).
  logic        m_busy, m_cpu, m_rnw, gc, gs, exp_cack, exp_sack;
  int          m_cnt, m_starve, n_ack, last_cpu;
  logic [12:0] m_addr;
  logic [7:0]  m_wdata;
  logic [7:0]  ref_mem [16];

  initial begin
    // inputs before edge k / outputs after edge k
    //             req rnw sreq ce oe we woe ca sa wn  addr     rd
    tbl[0]  = mk(0, 1, 0,  1, 1, 1, 0,  0, 0, 1, 13'h000, 8'h00);
    tbl[1]  = mk(1, 0, 0,  0, 1, 1, 1,  0, 0, 0, 13'h123, 8'h00);
    tbl[2]  = mk(1, 0, 0,  0, 1, 0, 1,  0, 0, 0, 13'h123, 8'h00);
    tbl[3]  = mk(1, 0, 0,  0, 1, 1, 1,  1, 0, 1, 13'h123, 8'h00);
    tbl[4]  = mk(0, 0, 0,  1, 1, 1, 0,  0, 0, 1, 13'h123, 8'h00);
    tbl[5]  = mk(1, 1, 0,  0, 1, 1, 0,  0, 0, 0, 13'h123, 8'h00);
    tbl[6]  = mk(1, 1, 0,  0, 0, 1, 0,  0, 0, 0, 13'h123, 8'h00);
    tbl[7]  = mk(1, 1, 0,  0, 1, 1, 0,  1, 0, 1, 13'h123, 8'hA5);
    tbl[8]  = mk(0, 1, 0,  1, 1, 1, 0,  0, 0, 1, 13'h123, 8'h00);
    tbl[9]  = mk(0, 1, 1,  0, 1, 1, 0,  0, 0, 1, 13'h040, 8'h00);
    tbl[10] = mk(0, 1, 1,  0, 0, 1, 0,  0, 0, 1, 13'h040, 8'h00);
    tbl[11] = mk(0, 1, 1,  0, 1, 1, 0,  0, 1, 1, 13'h040, 8'h3C);
    tbl[12] = mk(0, 1, 1,  0, 1, 1, 0,  0, 0, 1, 13'h040, 8'h00);
    tbl[13] = mk(0, 1, 1,  0, 0, 1, 0,  0, 0, 1, 13'h040, 8'h00);
    tbl[14] = mk(0, 1, 1,  0, 1, 1, 0,  0, 1, 1, 13'h040, 8'h3C);
    tbl[15] = mk(0, 1, 0,  1, 1, 1, 0,  0, 0, 1, 13'h040, 8'h00);

    // Asynchronous reset takes effect before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk1("rst ce_n", ram_ce_n, 1'b1);
    chk1("rst oe_n", ram_oe_n, 1'b1);
    chk1("rst we_n", ram_we_n, 1'b1);
    chk1("rst wdata_oe", ram_wdata_oe, 1'b0);
    chk1("rst cpu_ack", cpu_ack, 1'b0);
    chk1("rst scan_ack", scan_ack, 1'b0);
    chk1("rst wait_n", cpu_wait_n, 1'b1);
    chkv("rst ram_addr", 32'(ram_addr), 32'h0);
    chkv("rst ram_wdata", 32'(ram_wdata), 32'h0);
    chkv("rst cpu_rdata", 32'(cpu_rdata), 32'h0);
    chkv("rst scan_rdata", 32'(scan_rdata), 32'h0);
    repeat (2) @(posedge CLK_6M);
    #3 rst_n = 1'b1;

    // Cycle table: CPU write, CPU read-back, streamed scan reads.
    for (int i = 0; i < 16; i++) begin
      cpu_req = tbl[i].cpu_req; cpu_rnw = tbl[i].cpu_rnw; scan_req = tbl[i].scan_req;
      cpu_addr = 13'h123; cpu_wdata = 8'hA5; scan_addr = 13'h040;
      tick();
      chk1($sformatf("v%0d ce_n", i), ram_ce_n, tbl[i].ce_n);
      chk1($sformatf("v%0d oe_n", i), ram_oe_n, tbl[i].oe_n);
      chk1($sformatf("v%0d we_n", i), ram_we_n, tbl[i].we_n);
      chk1($sformatf("v%0d wdata_oe", i), ram_wdata_oe, tbl[i].woe);
      chk1($sformatf("v%0d cpu_ack", i), cpu_ack, tbl[i].cack);
      chk1($sformatf("v%0d scan_ack", i), scan_ack, tbl[i].sack);
      chk1($sformatf("v%0d wait_n", i), cpu_wait_n, tbl[i].wait_n);
      chkv($sformatf("v%0d ram_addr", i), 32'(ram_addr), 32'(tbl[i].addr));
      if (tbl[i].woe) chkv($sformatf("v%0d ram_wdata", i), 32'(ram_wdata), 32'hA5);
      if (tbl[i].cack) chkv($sformatf("v%0d cpu_rdata", i), 32'(cpu_rdata), 32'(tbl[i].rd));
      if (tbl[i].sack) chkv($sformatf("v%0d scan_rdata", i), 32'(scan_rdata), 32'(tbl[i].rd));
    end

    // Both requests held: four scan grants, then the starved CPU, repeating.
    cpu_req = 1'b1; cpu_rnw = 1'b1; scan_req = 1'b1;
    n_ack = 0; last_cpu = -1;
    for (int c = 0; c < 200 && n_ack < 10; c++) begin
      tick();
      if (cpu_ack || scan_ack) begin
        chk1($sformatf("order%0d cpu_owner", n_ack), cpu_ack, (n_ack % 5) == 4);
        if (cpu_ack) begin
          if (last_cpu >= 0) chkv("cpu_ack period", 32'(c - last_cpu), 32'd15);
          last_cpu = c;
        end
        n_ack++;
      end
    end
    chkv("order ack count", 32'(n_ack), 32'd10);
    cpu_req = 1'b0; scan_req = 1'b0;
    tick(); tick();

    // Reset during STROBE of a CPU write releases the SRAM at once; no ack, no write.
    cpu_req = 1'b1; cpu_rnw = 1'b0; cpu_addr = 13'h300; cpu_wdata = 8'h77;
    tick(); tick();
    chk1("rstw strobe we_n", ram_we_n, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk1("rstw we_n", ram_we_n, 1'b1);
    chk1("rstw wdata_oe", ram_wdata_oe, 1'b0);
    chk1("rstw ce_n", ram_ce_n, 1'b1);
    chk1("rstw cpu_ack", cpu_ack, 1'b0);
    cpu_req = 1'b0;
    @(posedge CLK_6M);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk1("rstw no ack", cpu_ack, 1'b0);
      chk1("rstw idle ce_n", ram_ce_n, 1'b1);
    end
    chkv("rstw sram untouched", 32'(sram[13'h300]), 32'(init_val(13'h300)));

    // Reset with the starvation count at its limit must clear it: scan wins first again.
    cpu_req = 1'b1; cpu_rnw = 1'b1; scan_req = 1'b1; n_ack = 0;
    for (int c = 0; c < 100 && n_ack < 3; c++) begin
      tick();
      if (scan_ack) n_ack++;
    end
    chkv("starve pre scans", 32'(n_ack), 32'd3);
    tick();
    #2 rst_n = 1'b0;
    @(posedge CLK_6M);
    #3 rst_n = 1'b1;
    n_ack = 0;
    for (int c = 0; c < 100 && n_ack < 5; c++) begin
      tick();
      if (cpu_ack || scan_ack) begin
        chk1($sformatf("post-rst order%0d cpu_owner", n_ack), cpu_ack, n_ack == 4);
        n_ack++;
      end
    end
    chkv("post-rst ack count", 32'(n_ack), 32'd5);
    cpu_req = 1'b0; scan_req = 1'b0;
    tick(); tick();

    // Address/data changed after grant: SRAM sees the granted values.
    cpu_req = 1'b1; cpu_rnw = 1'b0; cpu_addr = 13'h200; cpu_wdata = 8'h5A;
    tick();
    cpu_addr = 13'h1FF; cpu_wdata = 8'hFF;
    chkv("late ADDR ram_addr", 32'(ram_addr), 32'h200);
    chkv("late ADDR ram_wdata", 32'(ram_wdata), 32'h5A);
    tick();
    chkv("late STROBE ram_addr", 32'(ram_addr), 32'h200);
    chkv("late STROBE ram_wdata", 32'(ram_wdata), 32'h5A);
    tick();
    chk1("late cpu_ack", cpu_ack, 1'b1);
    cpu_req = 1'b0;
    tick();
    chkv("late sram[0x200]", 32'(sram[13'h200]), 32'h5A);
    chkv("late sram[0x1FF]", 32'(sram[13'h1FF]), 32'(init_val(13'h1FF)));
    tick();

    // Random traffic against a transaction-level model.
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(13'(i));
    m_busy = 1'b0; m_cnt = 0; m_starve = 0; m_cpu = 1'b0; m_rnw = 1'b1;
    m_addr = '0; m_wdata = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      exp_cack = m_busy && (m_cnt == 0) && m_cpu;
      exp_sack = m_busy && (m_cnt == 0) && !m_cpu;
      chk1("rnd cpu_ack", cpu_ack, exp_cack);
      chk1("rnd scan_ack", scan_ack, exp_sack);
      chk1("rnd wait_n", cpu_wait_n, !(cpu_req && !exp_cack));
      if (exp_cack && m_rnw)  chkv("rnd cpu_rdata", 32'(cpu_rdata), 32'(ref_mem[m_addr[3:0]]));
      if (exp_cack && !m_rnw) ref_mem[m_addr[3:0]] = m_wdata;
      if (exp_sack)           chkv("rnd scan_rdata", 32'(scan_rdata), 32'(ref_mem[m_addr[3:0]]));

      if (exp_cack) cpu_req = 1'b0;
      if (exp_sack) scan_req = 1'b0;
      if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_req = 1'b1;
        cpu_rnw = 1'($urandom_range(0, 1));
        cpu_addr = 13'($urandom_range(0, 15));
        cpu_wdata = 8'($urandom);
      end
      if (!scan_req && $urandom_range(0, 2) == 0) begin
        scan_req = 1'b1;
        scan_addr = 13'($urandom_range(0, 15));
      end

      gc = 1'b0; gs = 1'b0;
      if (!m_busy || m_cnt == 0) begin
        gc = cpu_req && (!scan_req || m_starve == STARVE_LIMIT);
        gs = scan_req && !gc;
        m_busy = gc || gs;
        if (m_busy) begin
          m_cnt = 2;
          m_cpu = gc;
          m_rnw = gc ? cpu_rnw : 1'b1;
          m_addr = gc ? cpu_addr : scan_addr;
          m_wdata = cpu_wdata;
        end
      end else begin
        m_cnt--;
      end
      if (!cpu_req || gc) m_starve = 0;
      else if (gs && m_starve < STARVE_LIMIT) m_starve++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
